a2b_link_fifo: RTL and testbench
================================

Name: a2b_link_fifo

Overview:
- Elastic buffer on the moduleA -> moduleB data path. It is instantiated in top between data_to_B of moduleA and data_from_A consumption in moduleB.
- Decouples producer and consumer timing with a valid/ready handshake on both sides.
- Storage is a power-of-two circular buffer. It provides first-word-fall-through output, a synchronous flush, and occupancy/high-water status for debug.

Parameters:
- DATA_WIDTH, 32, payload width; top sets it from `A_TO_B_BITWIDTH.
- DEPTH, 4, number of entries; must be a power of two and >= 2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy counters; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stored entries.
- in_data  input  DATA_WIDTH  payload from moduleA (data_to_B).
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  buffer can accept an entry this cycle.
- out_data  output  DATA_WIDTH  head entry toward moduleB.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  moduleB accepts the head this cycle.
- level  output  CNT_WIDTH  current number of stored entries (0..DEPTH).
- high_water  output  CNT_WIDTH  maximum level reached since reset or flush.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1:
  - wr_ptr=0, rd_ptr=0, level=0, high_water=0.
  - out_valid=0, in_ready=0, out_data=0.
  - Storage RAM contents are not reset.
- First clk edge after rst deasserts: in_ready rises to 1.
  - in_ready is registered and is 0 only during reset.
  - No transfer is accepted on that first edge.
- Push: occurs when in_valid & in_ready at a clk edge. Writes mem[wr_ptr], then wr_ptr increments and wraps modulo DEPTH.
- Pop: occurs when out_valid & out_ready at a clk edge. rd_ptr increments modulo DEPTH.
- in_ready: registered, equal to (next level < DEPTH).
  - It does not depend combinationally on out_ready.
  - A push is refused when full, even if a pop happens in the same cycle.
- out_valid = (level != 0). out_data = mem[rd_ptr], combinational read (FWFT).
  - Push-to-out_valid latency when empty: 1 cycle. The entry written at edge N is visible after edge N.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Simultaneous push and pop at level=1: level stays 1, and the new entry becomes the head.
- Full (level=DEPTH): in_ready=0. Holding in_valid=1 while full causes no overwrite; the data must be held by the producer.
- Empty (level=0): out_valid=0. out_ready is ignored and rd_ptr does not move.
- Pointer wrap: wr_ptr and rd_ptr are log2(DEPTH)-bit values and wrap from DEPTH-1 to 0. There is no special case at the wrap.
- high_water: updated at each edge to max(high_water, next level). It saturates at DEPTH.
- flush (synchronous, highest priority after rst):
  - On the edge with flush=1: pointers -> 0, level -> 0, high_water -> 0, out_valid -> 0.
  - Any push or pop in that cycle is discarded and not counted.
  - in_ready -> 1 on that edge.
- Ordering: strict FIFO. No entry is dropped or duplicated under any mix of stalls.
- Reset mid-transfer: all in-flight and stored entries are lost. Producers must re-send.
- Assertion targets for verification:
  - never (push & level==DEPTH)
  - never (pop & level==0)
  - level <= DEPTH
  - high_water >= level

Test Plan (DATA_WIDTH=8, DEPTH=4 unless noted):
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, level=0. First edge after release: in_ready=1, with no entry stored.
- Fill/drain: push 0x11,0x22,0x33,0x44 with out_ready=0 -> level=4, in_ready=0, high_water=4. A 5th value 0x55 is held and not accepted. Then out_ready=1 -> 0x11,0x22,0x33,0x44 appear in order, level returns to 0, and 0x55 enters once in_ready=1.
- Concurrent streaming: in_valid=1 and out_ready=1 every cycle for 20 items 0x00..0x13 -> level stays at 1 after the first push. Output matches input order with 1-cycle latency. high_water=1.
- Wrap-around: 10 push/pop pairs interleaved with level oscillating 0..3 -> pointers wrap at least twice. Output data order is intact and high_water=3.
- Flush: level=3 (0xA0,0xA1,0xA2) with push 0xA3 and pop in the same cycle, plus flush=1 -> after the edge level=0, out_valid=0, high_water=0, and 0xA3 is not stored. A following push of 0xB0 is output as the head.
- Random stall stress: random in_valid/out_ready at 50% for 2000 cycles against a reference queue model -> zero mismatches and no assertion failures. Async rst pulse mid-run clears level to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/a2b_link_fifo_if.sv
// Handshake bundle for the moduleA -> moduleB elastic buffer.
// The producer side (in_*) and the consumer side (out_*) travel together so that
// the buffer exposes a single bus port. The buffer uses the slave view and the
// surrounding logic uses the master view.
interface a2b_link_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/a2b_link_fifo.sv
// Elastic first-word-fall-through buffer between moduleA and moduleB.
// It uses power-of-two circular storage with a registered in_ready, a synchronous
// flush, and occupancy and high-water status. A small checker module holds the
// structural invariants as concurrent assertions.

module a2b_link_fifo_checker #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 push,
  input logic                 pop,
  input logic [CNT_WIDTH-1:0] level,
  input logic [CNT_WIDTH-1:0] high_water
);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && (level == DEPTH_C)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && (level == '0)));
  a_level_bound:  assert property (@(posedge clk) disable iff (rst) level <= DEPTH_C);
  a_hw_ge_level:  assert property (@(posedge clk) disable iff (rst) high_water >= level);
endmodule

module a2b_link_fifo #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 4,
  localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  a2b_link_fifo_if.slave       bus,
  output logic [CNT_WIDTH-1:0] level,
  output logic [CNT_WIDTH-1:0] high_water
);
  localparam int                   PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  level_r;
  logic [CNT_WIDTH-1:0]  high_water_r;
  logic                  in_ready_r;

  logic [CNT_WIDTH-1:0]  level_nxt_s;
  logic [CNT_WIDTH-1:0]  high_water_nxt_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  out_valid_s;

  // A push requires the registered ready. A full buffer therefore refuses
  // input even when a pop happens in the same cycle.
  assign out_valid_s = (level_r != '0);
  assign push_s      = bus.in_valid & in_ready_r;
  assign pop_s       = out_valid_s & bus.out_ready;

  // Compute the next occupancy and the running maximum of occupancy.
  always_comb begin
    level_nxt_s      = level_r;
    high_water_nxt_s = high_water_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + CNT_WIDTH'(1);
      2'b01:   level_nxt_s = level_r - CNT_WIDTH'(1);
      default: level_nxt_s = level_r;
    endcase
    if (level_nxt_s > high_water_r) begin
      high_water_nxt_s = level_nxt_s;
    end else begin
      high_water_nxt_s = high_water_r;
    end
  end

  // Update pointers, occupancy, high-water and ready. A flush clears all of
  // them and reopens the input, and any transfer in that cycle is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      high_water_r <= '0;
      in_ready_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      level_r      <= '0;
      high_water_r <= '0;
      in_ready_r   <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
      end
      level_r      <= level_nxt_s;
      high_water_r <= high_water_nxt_s;
      in_ready_r   <= (level_nxt_s < DEPTH_C);
    end
  end

  // Write the storage array. It is not reset, because entries are only
  // visible once they are counted in the occupancy.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // The head is read combinationally (fall-through) and forced to zero while
  // the buffer is empty, so reset never exposes stale RAM contents.
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_valid_s ? mem_r[rd_ptr_r] : '0;
  assign level         = level_r;
  assign high_water    = high_water_r;

  a2b_link_fifo_checker #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .level      (level_r),
    .high_water (high_water_r)
  );
endmodule

// File: tb/tb_a2b_link_fifo.sv
// Self-checking bench for a2b_link_fifo (DATA_WIDTH=8, DEPTH=4).
// The reference is a queue that follows the buffer's transfer rules directly.
module tb_a2b_link_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] level;
  logic [2:0] high_water;

  a2b_link_fifo_if #(.DATA_WIDTH(DW)) bus ();

  a2b_link_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .level      (level),
    .high_water (high_water)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [7:0]  q [$];
  int          hw_m   = 0;
  bit          rdy_m  = 1'b0;

  // Advance one clock edge and apply the same edge to the reference queue.
  task automatic step(output bit pushed, output bit popped);
    logic [7:0] tmp;
    pushed = (bus.in_valid === 1'b1) && rdy_m && !flush;
    popped = (bus.out_ready === 1'b1) && (q.size() != 0) && !flush;
    if (flush) begin
      q.delete();
      hw_m = 0;
    end else begin
      if (popped) tmp = q.pop_front();
      if (pushed) q.push_back(bus.in_data);
    end
    if (q.size() > hw_m) hw_m = q.size();
    rdy_m = (q.size() < DEPTH);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    bit p, o;
    flush = 1'b1;
    step(p, o);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    bit p, o;
    repeat (3) @(posedge clk);
    #1;
    n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", bus.in_ready); end
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); end
    n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d exp 0", level); end
    n_run++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h exp 00", bus.out_data); end
    rst = 1'b0;
    step(p, o);
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b exp 1", bus.in_ready); end
    n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL rel_level: got %0d exp 0", level); end
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid: got %b exp 0", bus.out_valid); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_fill_drain();
    bit p, o;
    int k;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'((i + 1) * 17);
      step(p, o);
    end
    n_run++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d exp 4", level); end
    n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b exp 0", bus.in_ready); end
    n_run++; if (high_water !== 3'd4) begin n_fail++; $display("FAIL fill_hw: got %0d exp 4", high_water); end
    n_run++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL fill_head: got %h exp 11", bus.out_data); end
    bus.in_data = 8'h55;
    step(p, o);
    step(p, o);
    n_run++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_hold_level: got %0d exp 4", level); end
    n_run++; if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL full_hold_head: got %h exp 11", bus.out_data); end
    bus.out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      if (bus.out_valid === 1'b1) begin
        n_run++; if (bus.out_data !== 8'((k + 1) * 17)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h exp %h", k, bus.out_data, 8'((k + 1) * 17)); end
        k++;
      end
      step(p, o);
      if (p) bus.in_valid = 1'b0;
    end
    n_run++; if (k != 5) begin n_fail++; $display("FAIL drain_count: got %0d exp 5", k); end
    n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d exp 0", level); end
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: got %b exp 0", bus.out_valid); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stream();
    bit p, o;
    int sent, recv;
    flush_pulse();
    bus.out_ready = 1'b1;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 60 && recv < 20; c++) begin
      bus.in_valid = (sent < 20);
      bus.in_data  = 8'(sent);
      if (bus.out_valid === 1'b1) begin
        n_run++; if (bus.out_data !== 8'(recv)) begin n_fail++; $display("FAIL stream_data: got %h exp %h", bus.out_data, 8'(recv)); end
      end
      step(p, o);
      if (p) sent++;
      if (o) recv++;
      n_run++; if (level !== 3'(sent - recv)) begin n_fail++; $display("FAIL stream_level: got %0d exp %0d", level, sent - recv); end
    end
    n_run++; if (recv != 20) begin n_fail++; $display("FAIL stream_count: got %0d exp 20", recv); end
    n_run++; if (high_water !== 3'd1) begin n_fail++; $display("FAIL stream_hw: got %0d exp 1", high_water); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit p, o;
    int sent, recv, n;
    flush_pulse();
    sent = 0;
    recv = 0;
    for (int b = 0; b < 4; b++) begin
      n = ((10 - sent) < 3) ? (10 - sent) : 3;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        bus.in_data = 8'hC0 + 8'(sent);
        step(p, o);
        if (p) sent++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
        n_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0 + 8'(recv)) begin n_fail++; $display("FAIL wrap_data: got %b/%h exp 1/%h", bus.out_valid, bus.out_data, 8'hC0 + 8'(recv)); end
        step(p, o);
        if (o) recv++;
      end
      bus.out_ready = 1'b0;
      n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL wrap_level: got %0d exp 0", level); end
    end
    n_run++; if (recv != 10) begin n_fail++; $display("FAIL wrap_count: got %0d exp 10", recv); end
    n_run++; if (high_water !== 3'd3) begin n_fail++; $display("FAIL wrap_hw: got %0d exp 3", high_water); end
  endtask

  task automatic test_flush();
    bit p, o;
    flush_pulse();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'hA0 + 8'(i);
      step(p, o);
    end
    n_run++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_level: got %0d exp 3", level); end
    bus.in_data   = 8'hA3;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    step(p, o);
    flush = 1'b0;
    n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d exp 0", level); end
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b exp 0", bus.out_valid); end
    n_run++; if (high_water !== 3'd0) begin n_fail++; $display("FAIL flush_hw: got %0d exp 0", high_water); end
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b exp 1", bus.in_ready); end
    bus.in_data   = 8'hB0;
    bus.out_ready = 1'b0;
    step(p, o);
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB0) begin n_fail++; $display("FAIL flush_next_head: got %b/%h exp 1/b0", bus.out_valid, bus.out_data); end
    n_run++; if (level !== 3'd1) begin n_fail++; $display("FAIL flush_next_level: got %0d exp 1", level); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step(p, o);
    bus.out_ready = 1'b0;
    n_run++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_drain_level: got %0d exp 0", level); end
  endtask

  task automatic test_random();
    bit p, o;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        #2 rst = 1'b1;
        #1;
        n_run++; if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || high_water !== 3'd0) begin
          n_fail++; $display("FAIL async_rst: got lvl=%0d ov=%b ir=%b hw=%0d exp 0/0/0/0", level, bus.out_valid, bus.in_ready, high_water);
        end
        q.delete();
        hw_m  = 0;
        rdy_m = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data   = 8'($urandom);
      n_run++; if (bus.out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %b exp %b", c, bus.out_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        n_run++; if (bus.out_data !== q[0]) begin n_fail++; $display("FAIL rand_out_data c=%0d: got %h exp %h", c, bus.out_data, q[0]); end
      end
      step(p, o);
      n_run++; if (level !== 3'(q.size())) begin n_fail++; $display("FAIL rand_level c=%0d: got %0d exp %0d", c, level, q.size()); end
      n_run++; if (bus.in_ready !== rdy_m) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %b exp %b", c, bus.in_ready, rdy_m); end
      n_run++; if (high_water !== 3'(hw_m)) begin n_fail++; $display("FAIL rand_hw c=%0d: got %0d exp %0d", c, high_water, hw_m); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h99;
    bus.out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_wrap();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
